// File: rtl/intersection_ctrl_if.sv
// Signal bundle between an intersection sequencer and its user: request and hold inputs, lamp, countdown and status outputs.
// Latency: wires only, no storage.
// Backpressure: none; the requests are level/pulse inputs that are sampled every cycle.
//
// Signals:
//   ped_req_ns, ped_req_ew : requests to serve NS / EW
//   hold                   : freezes the phase and the countdown while high
//   ns_* / ew_*            : lamp drives, one lamp per direction on at a time
//   clock                  : cycles remaining in the current phase
//   phase                  : current phase code
//   req_pend               : {ew_latched, ns_latched}
//
// Modports:
//   master : the driver / display side
//   slave  : the sequencer
interface intersection_ctrl_if;
  logic       ped_req_ns;
  logic       ped_req_ew;
  logic       hold;
  logic       ns_red;
  logic       ns_yellow;
  logic       ns_green;
  logic       ew_red;
  logic       ew_yellow;
  logic       ew_green;
  logic [7:0] clock;
  logic [2:0] phase;
  logic [1:0] req_pend;

  modport master (
    output ped_req_ns, ped_req_ew, hold,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    input  clock, phase, req_pend
  );

  modport slave (
    input  ped_req_ns, ped_req_ew, hold,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    output clock, phase, req_pend
  );
endinterface

// File: rtl/intersection_ctrl.sv
// Six-phase two-direction traffic sequencer with all-red clearance, request latches and green shortening.
// Latency: a phase change appears one clk edge after the cycle that ends the phase; the lamps decode the registered state.
// Backpressure: none; hold freezes the phase and the countdown, and the request latches keep sampling.
//
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset that forces AR_B and clears both request latches
//   bus   : intersection_ctrl_if.slave (requests and hold in; lamps, clock, phase and req_pend out)
module intersection_ctrl #(
  parameter int GREEN_CNT  = 60,
  parameter int YELLOW_CNT = 5,
  parameter int ALLRED_CNT = 2,
  parameter int PED_CNT    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  intersection_ctrl_if.slave  bus
);

  // Phase codes. These codes also appear on the phase output.
  localparam logic [2:0] NS_G = 3'd0;
  localparam logic [2:0] NS_Y = 3'd1;
  localparam logic [2:0] AR_A = 3'd2;
  localparam logic [2:0] EW_G = 3'd3;
  localparam logic [2:0] EW_Y = 3'd4;
  localparam logic [2:0] AR_B = 3'd5;

  localparam logic [7:0] GREEN_V  = 8'(GREEN_CNT);
  localparam logic [7:0] YELLOW_V = 8'(YELLOW_CNT);
  localparam logic [7:0] ALLRED_V = 8'(ALLRED_CNT);
  localparam logic [7:0] PED_V    = 8'(PED_CNT);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       ns_lat_q, ns_lat_d;
  logic       ew_lat_q, ew_lat_d;

  logic       shorten;
  logic       enter_ns_g;
  logic       enter_ew_g;

  // Duration that is loaded on entry to a phase.
  function automatic logic [7:0] dur_of(input logic [2:0] s);
    case (s)
      NS_G, EW_G: dur_of = GREEN_V;
      NS_Y, EW_Y: dur_of = YELLOW_V;
      default:    dur_of = ALLRED_V;
    endcase
  endfunction

  // Fixed cycle order. An unused code falls back to the clearance phase.
  function automatic logic [2:0] succ(input logic [2:0] s);
    case (s)
      NS_G:    succ = NS_Y;
      NS_Y:    succ = AR_A;
      AR_A:    succ = EW_G;
      EW_G:    succ = EW_Y;
      EW_Y:    succ = AR_B;
      AR_B:    succ = NS_G;
      default: succ = AR_B;
    endcase
  endfunction

  // A live request counts as well as a latched one, so a one-cycle pulse shortens the green at once.
  // The cnt > PED_V guard keeps the countdown from increasing.
  always_comb begin
    shorten = 1'b0;
    if (cnt_q > PED_V) begin
      if (state_q == NS_G && (ew_lat_q || bus.ped_req_ew))
        shorten = 1'b1;
      if (state_q == EW_G && (ns_lat_q || bus.ped_req_ns))
        shorten = 1'b1;
    end
  end

  // Next-state and countdown logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q > AR_B) begin
      // Codes 6 and 7 go to clearance regardless of hold. This keeps the lamps in a safe state.
      state_d = AR_B;
      cnt_d   = ALLRED_V;
    end else if (!bus.hold) begin
      if (cnt_q <= 8'd1) begin
        state_d = succ(state_q);
        cnt_d   = dur_of(succ(state_q));
      end else if (shorten) begin
        cnt_d = PED_V;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  // A latch is cleared on the edge that enters its own green. The clear wins over a set in the same cycle.
  assign enter_ns_g = (state_d == NS_G) && (state_q != NS_G);
  assign enter_ew_g = (state_d == EW_G) && (state_q != EW_G);

  always_comb begin
    ns_lat_d = ns_lat_q | (bus.ped_req_ns && (state_q != NS_G));
    ew_lat_d = ew_lat_q | (bus.ped_req_ew && (state_q != EW_G));
    if (enter_ns_g)
      ns_lat_d = 1'b0;
    if (enter_ew_g)
      ew_lat_d = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= AR_B;
      cnt_q    <= ALLRED_V;
      ns_lat_q <= 1'b0;
      ew_lat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ns_lat_q <= ns_lat_d;
      ew_lat_q <= ew_lat_d;
    end
  end

  // Output decode. Each direction has exactly one lamp on, and red is the fallback.
  always_comb begin
    bus.ns_red    = 1'b1;
    bus.ns_yellow = 1'b0;
    bus.ns_green  = 1'b0;
    bus.ew_red    = 1'b1;
    bus.ew_yellow = 1'b0;
    bus.ew_green  = 1'b0;
    case (state_q)
      NS_G: begin
        bus.ns_red   = 1'b0;
        bus.ns_green = 1'b1;
      end
      NS_Y: begin
        bus.ns_red    = 1'b0;
        bus.ns_yellow = 1'b1;
      end
      EW_G: begin
        bus.ew_red   = 1'b0;
        bus.ew_green = 1'b1;
      end
      EW_Y: begin
        bus.ew_red    = 1'b0;
        bus.ew_yellow = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.clock    = cnt_q;
  assign bus.phase    = state_q;
  assign bus.req_pend = {ew_lat_q, ns_lat_q};

endmodule
